// File: rtl/memory_access.sv
// Memory stage of the in-order pipeline: issues one data-memory access per load/store,
// holds the bus request until dmem_ready, and passes every other instruction straight through.
module memory_access #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] instr_in,
   input  logic [XLEN-1:0] data_in,
   input  logic [XLEN-1:0] store_val,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_wstrb,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            stall_m,
   output logic            valid_out,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] result_out,
   output logic            misalign
);

   typedef logic [XLEN-1:0] word_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_load;
   logic       is_store;
   logic       mem_ok;
   logic       aligned;
   logic       accept;
   logic       go_busy;
   logic       retire_mem;
   word_t      result_nxt;

   word_t      addr_p1;
   logic [1:0] off_p1;
   logic [2:0] funct3_p1;
   logic       we_p1;
   logic [3:0] wstrb_p1;
   word_t      wdata_p1;
   word_t      pc_p1;
   word_t      instr_p1;

   function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
      logic ok;
      case (f3[1:0])
         2'b00:   ok = 1'b1;
         2'b01:   ok = ~a[0];
         default: ok = (a == 2'b00);
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
      logic [3:0] s;
      case (f3[1:0])
         2'b00:   s = 4'b0001 << a;
         2'b01:   s = 4'b0011 << a;
         default: s = 4'hF;
      endcase
      return s;
   endfunction

   function automatic word_t store_data(input logic [2:0] f3, input word_t v);
      word_t d;
      case (f3[1:0])
         2'b00:   d = {(XLEN/8){v[7:0]}};
         2'b01:   d = {(XLEN/16){v[15:0]}};
         default: d = v;
      endcase
      return d;
   endfunction

   // Lane select then sign/zero extension of the returned word.
   function automatic word_t load_data(input logic [2:0] f3, input logic [1:0] a, input word_t rd);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      word_t              r;
      b = rd[{a, 3'b000} +: 8];
      h = a[1] ? rd[31:16] : rd[15:0];
      case (f3)
         3'b000:  r = {{(XLEN-8){b[7]}}, b};
         3'b001:  r = {{(XLEN-16){h[15]}}, h};
         3'b010:  r = rd;
         3'b100:  r = {{(XLEN-8){1'b0}}, b};
         3'b101:  r = {{(XLEN-16){1'b0}}, h};
         default: r = '0;
      endcase
      return r;
   endfunction

   assign opcode   = instr_in[6:0];
   assign funct3   = instr_in[14:12];
   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      go_busy    = 1'b0;
      retire_mem = 1'b0;
      mem_ok     = (is_load  && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
                   (is_store && (funct3 inside {3'b000, 3'b001, 3'b010}));
      aligned    = is_aligned(funct3, data_in[1:0]);
      // Undefined-funct3 memory ops and misaligned ops both retire with a zero result.
      result_nxt = (is_load || is_store) ? '0 : data_in;
      case (state)
         IDLE: begin
            accept = valid_in;
            if (valid_in && mem_ok && aligned) begin
               go_busy   = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (dmem_ready) begin
               retire_mem = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Stage p1: accepted memory request, held stable while the bus is busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_p1   <= '0;
         off_p1    <= '0;
         funct3_p1 <= '0;
         we_p1     <= 1'b0;
         wstrb_p1  <= '0;
         wdata_p1  <= '0;
         pc_p1     <= '0;
         instr_p1  <= '0;
      end else if (go_busy) begin
         addr_p1   <= {data_in[XLEN-1:2], 2'b00};
         off_p1    <= data_in[1:0];
         funct3_p1 <= funct3;
         we_p1     <= is_store;
         wstrb_p1  <= is_store ? store_strb(funct3, data_in[1:0]) : 4'b0000;
         wdata_p1  <= is_store ? store_data(funct3, store_val) : '0;
         pc_p1     <= pc_in;
         instr_p1  <= instr_in;
      end
   end

   // Stage p2: retirement registers toward Writeback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out  <= 1'b0;
         pc_out     <= '0;
         instr_out  <= '0;
         result_out <= '0;
         misalign   <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         if (accept && !go_busy) begin
            valid_out  <= 1'b1;
            pc_out     <= pc_in;
            instr_out  <= instr_in;
            result_out <= result_nxt;
            misalign   <= mem_ok && !aligned;
         end else if (retire_mem) begin
            valid_out  <= 1'b1;
            pc_out     <= pc_p1;
            instr_out  <= instr_p1;
            result_out <= we_p1 ? '0 : load_data(funct3_p1, off_p1, dmem_rdata);
            misalign   <= 1'b0;
         end
      end
   end

   assign dmem_req   = (state == BUSY);
   assign stall_m    = (state == BUSY);
   assign dmem_addr  = addr_p1;
   assign dmem_we    = we_p1;
   assign dmem_wstrb = wstrb_p1;
   assign dmem_wdata = wdata_p1;

endmodule
